// File: rtl/score_pkg.sv
// Shared types, constants and BCD step helpers for the score accumulation stage.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2
    } state_t;

    localparam logic TEAM_A = 1'b0;
    localparam logic TEAM_B = 1'b1;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Key vector layout; a higher index wins when edges coincide.
    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned KEY_B1   = 0;
    localparam int unsigned KEY_B2   = 1;
    localparam int unsigned KEY_B3   = 2;
    localparam int unsigned KEY_A1   = 3;
    localparam int unsigned KEY_A2   = 4;
    localparam int unsigned KEY_A3   = 5;
    localparam int unsigned KEY_UNDO = 6;
    localparam int unsigned KEY_CLR  = 7;

    localparam int unsigned CNT_W = 2;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD register with increment/decrement enables, synchronous clear,
// and saturation at 00 and MAX.
module bcd2_updown
    import score_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_val
);

    logic [7:0] r_val;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_val <= 8'h00;
        end else if (i_inc && (r_val != MAX)) begin
            r_val <= bcd_inc(r_val);
        end else if (i_dec && (r_val != 8'h00)) begin
            r_val <= bcd_dec(r_val);
        end
    end

    assign o_val = r_val;

endmodule

// File: rtl/score_keeper.sv
// Key-edge front end, serial one-point-per-cycle add/undo FSM and per-team
// BCD score registers producing the packed display score word.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  MAX_BCD     = BCD_MAX
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        key_a1,
    input  logic        key_a2,
    input  logic        key_a3,
    input  logic        key_b1,
    input  logic        key_b2,
    input  logic        key_b3,
    input  logic        key_undo,
    input  logic        key_clr,
    output logic [15:0] score,
    output logic        busy,
    output logic        score_upd
);

    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

    logic [NUM_KEYS-1:0] w_raw;
    logic [NUM_KEYS-1:0] w_edge;
    logic [FILL_W-1:0]   r_fill;
    logic                w_primed;

    assign w_raw[KEY_B1]   = key_b1;
    assign w_raw[KEY_B2]   = key_b2;
    assign w_raw[KEY_B3]   = key_b3;
    assign w_raw[KEY_A1]   = key_a1;
    assign w_raw[KEY_A2]   = key_a2;
    assign w_raw[KEY_A3]   = key_a3;
    assign w_raw[KEY_UNDO] = key_undo;
    assign w_raw[KEY_CLR]  = key_clr;

    // Edges are suppressed until the history flop holds a real post-reset
    // sample, so a key held through reset never fires on its own.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_fill <= '0;
        end else if (r_fill != FILL_DONE) begin
            r_fill <= r_fill + FILL_W'(1);
        end
    end

    assign w_primed = (r_fill == FILL_DONE);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_sync <= '0;
                r_hist <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                r_hist <= r_sync[SYNC_STAGES-1];
            end
        end

        assign w_edge[g] = r_sync[SYNC_STAGES-1] & ~r_hist & w_primed;
    end

    logic             w_sel_valid;
    logic             w_sel_team;
    logic [CNT_W-1:0] w_sel_pts;

    // Highest-priority scoring edge; undo and clear are handled by the FSM.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_team  = TEAM_A;
        w_sel_pts   = '0;
        if (w_edge[KEY_A3]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_A;
            w_sel_pts   = CNT_W'(3);
        end else if (w_edge[KEY_A2]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_A;
            w_sel_pts   = CNT_W'(2);
        end else if (w_edge[KEY_A1]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_A;
            w_sel_pts   = CNT_W'(1);
        end else if (w_edge[KEY_B3]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_B;
            w_sel_pts   = CNT_W'(3);
        end else if (w_edge[KEY_B2]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_B;
            w_sel_pts   = CNT_W'(2);
        end else if (w_edge[KEY_B1]) begin
            w_sel_valid = 1'b1;
            w_sel_team  = TEAM_B;
            w_sel_pts   = CNT_W'(1);
        end
    end

    state_t           r_state;
    logic             r_team;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_applied;
    logic             r_rec_valid;
    logic             r_rec_team;
    logic [CNT_W-1:0] r_rec_applied;
    logic             r_busy;
    logic             r_upd;

    logic [7:0] w_val_a;
    logic [7:0] w_val_b;
    logic [7:0] w_team_val;
    logic       w_clr;
    logic       w_add_step;
    logic       w_sub_step;

    assign w_clr      = w_edge[KEY_CLR];
    assign w_team_val = (r_team == TEAM_B) ? w_val_b : w_val_a;
    assign w_add_step = (r_state == ADD) && (r_cnt != '0) && (w_team_val != MAX_BCD);
    assign w_sub_step = (r_state == SUB) && (r_cnt != '0);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= IDLE;
            r_team        <= TEAM_A;
            r_cnt         <= '0;
            r_applied     <= '0;
            r_rec_valid   <= 1'b0;
            r_rec_team    <= TEAM_A;
            r_rec_applied <= '0;
            r_busy        <= 1'b0;
            r_upd         <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_clr) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_applied   <= '0;
                r_rec_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_upd       <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_edge[KEY_UNDO]) begin
                            if (r_rec_valid) begin
                                r_team  <= r_rec_team;
                                r_cnt   <= r_rec_applied;
                                r_state <= SUB;
                                r_busy  <= 1'b1;
                            end
                        end else if (w_sel_valid) begin
                            r_team    <= w_sel_team;
                            r_cnt     <= w_sel_pts;
                            r_applied <= '0;
                            r_state   <= ADD;
                            r_busy    <= 1'b1;
                        end
                    end
                    ADD: begin
                        if (w_add_step) begin
                            r_cnt     <= r_cnt - CNT_W'(1);
                            r_applied <= r_applied + CNT_W'(1);
                        end else begin
                            // Record what was really applied so undo is exact after clipping.
                            r_state       <= IDLE;
                            r_busy        <= 1'b0;
                            r_upd         <= 1'b1;
                            r_rec_valid   <= 1'b1;
                            r_rec_team    <= r_team;
                            r_rec_applied <= r_applied;
                        end
                    end
                    SUB: begin
                        if (w_sub_step) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_upd       <= 1'b1;
                            r_rec_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    bcd2_updown #(
        .MAX   (MAX_BCD)
    ) u_team_a (
        .i_clk (clk_in),
        .i_rst (rst),
        .i_clr (w_clr),
        .i_inc (w_add_step && (r_team == TEAM_A)),
        .i_dec (w_sub_step && (r_team == TEAM_A)),
        .o_val (w_val_a)
    );

    bcd2_updown #(
        .MAX   (MAX_BCD)
    ) u_team_b (
        .i_clk (clk_in),
        .i_rst (rst),
        .i_clr (w_clr),
        .i_inc (w_add_step && (r_team == TEAM_B)),
        .i_dec (w_sub_step && (r_team == TEAM_B)),
        .o_val (w_val_b)
    );

    assign score     = {w_val_a, w_val_b};
    assign busy      = r_busy;
    assign score_upd = r_upd;

endmodule
